pixel_bank_engine: RTL and testbench

PIXEL_BANK_ENGINE -- requirements
Module: pixel_bank_engine

---
 rtl/pixel_bank_engine.sv | 152 +++++++++++++++
 tb/tb_pixel_bank_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bank_engine.sv
// Purpose: buffers one frame of CH pixel channels, then drains it as PACK-pixel words per channel.
// Latency: first out_valid 2 cycles after the last pixel is written; then one word per cycle.
// Backpressure: in_ready only in FILL; out_data/out_valid held while out_ready=0, prefetch keeps the stream bubble-free.
//
// Ports:
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   start, rev        frame-start request and lane-order mode (rev latched on an accepted start)
//   in_valid/in_ready/in_data     one pixel per channel per handshake, channel c at [c*PIX_W +: PIX_W]
//   out_valid/out_ready/out_data  packed words, channel c lane j at [(c*PACK+j)*PIX_W +: PIX_W]
//   busy, complete    FILL/DRAIN in progress, frame fully drained
module pixel_bank_engine #(
    parameter int CH    = 2,
    parameter int PIX_W = 8,
    parameter int PACK  = 4,
    parameter int DEPTH = 2048
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic                      rev,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH*PIX_W-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH*PACK*PIX_W-1:0]  out_data,
    output logic                      busy,
    output logic                      complete
);

    localparam int WORDS = DEPTH / PACK;
    localparam int WA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RA_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BK_W  = (PACK > 1)  ? $clog2(PACK)  : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [WA_W-1:0] wr_addr;
    logic [RA_W-1:0] rd_addr;
    logic [RA_W-1:0] tx_cnt;
    logic            rd_all;     // every word address has been issued to the RAM
    logic            rq_vld;     // RAM read register holds a word not yet moved to the output
    logic            rev_q;

    logic            start_ok, wr_en, wr_last, rd_en, load, xfer, tx_last;
    logic [BK_W-1:0] wr_bank;
    logic [RA_W-1:0] wr_row;
    logic [CH*PACK*PIX_W-1:0] ram_word;
    logic [CH*PACK*PIX_W-1:0] lane_nxt;

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign wr_en    = (state == S_FILL) && in_valid;
    assign wr_last  = wr_en && (wr_addr == WA_W'(DEPTH - 1));
    assign xfer     = out_valid && out_ready;
    assign tx_last  = xfer && (tx_cnt == RA_W'(WORDS - 1));
    // The read register refills whenever its word leaves for the output register,
    // so a held-high out_ready sees one word per cycle.
    assign load     = rq_vld && (!out_valid || out_ready);
    assign rd_en    = (state == S_DRAIN) && !rd_all && (!rq_vld || load);

    // Pixel i lives in bank (i mod PACK), row (i / PACK): a word read hits every bank at one row.
    assign wr_bank  = BK_W'(wr_addr % PACK);
    assign wr_row   = RA_W'(wr_addr / PACK);

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)   state_nxt = S_FILL;
            S_FILL:         if (wr_last) state_nxt = S_DRAIN;
            S_DRAIN:        if (tx_last) state_nxt = S_DONE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        complete = 1'b0;
        case (state)
            S_FILL:  begin in_ready = 1'b1; busy = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_DONE:  complete = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            tx_cnt    <= '0;
            rd_all    <= 1'b0;
            rq_vld    <= 1'b0;
            rev_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (start_ok) begin
                wr_addr <= '0;
                rd_addr <= '0;
                tx_cnt  <= '0;
                rd_all  <= 1'b0;
                rev_q   <= rev;
            end else begin
                // Counters stop on their last value rather than wrapping.
                if (wr_en && !wr_last) wr_addr <= wr_addr + WA_W'(1);
                if (rd_en) begin
                    if (rd_addr == RA_W'(WORDS - 1)) rd_all  <= 1'b1;
                    else                             rd_addr <= rd_addr + RA_W'(1);
                end
                if (xfer && !tx_last) tx_cnt <= tx_cnt + RA_W'(1);
            end
            rq_vld <= rd_en || (rq_vld && !load);
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= lane_nxt;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar b = 0; b < PACK; b++) begin : g_bank
            logic [PIX_W-1:0] mem [WORDS];
            logic [PIX_W-1:0] q;
            always_ff @(posedge CLK) begin
                if (wr_en && (wr_bank == BK_W'(b))) mem[wr_row] <= in_data[c*PIX_W +: PIX_W];
                if (rd_en) q <= mem[rd_addr];
            end
            assign ram_word[(c*PACK+b)*PIX_W +: PIX_W] = q;
        end
    end

    // Lane j takes bank j, or bank PACK-1-j in reversed mode.
    always_comb begin
        lane_nxt = '0;
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < PACK; j++) begin
                if (rev_q) lane_nxt[(c*PACK+j)*PIX_W +: PIX_W] = ram_word[(c*PACK+PACK-1-j)*PIX_W +: PIX_W];
                else       lane_nxt[(c*PACK+j)*PIX_W +: PIX_W] = ram_word[(c*PACK+j)*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: tb/tb_pixel_bank_engine.sv
module tb_pixel_bank_engine;

    localparam int CH    = 2;
    localparam int PIX_W = 8;
    localparam int PACK  = 4;
    localparam int DEPTH = 2048;
    localparam int WORDS = DEPTH / PACK;
    localparam int W     = CH * PACK * PIX_W;

    logic CLK = 1'b0;
    logic RESET, start, rev, in_valid, in_ready, out_valid, out_ready, busy, complete;
    logic [CH*PIX_W-1:0] in_data;
    logic [W-1:0]        out_data;

    pixel_bank_engine #(.CH(CH), .PIX_W(PIX_W), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .rev(rev),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .complete(complete)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_cnt  = WORDS;    // next expected word index; WORDS means no word is expected
    bit mdl_rev  = 1'b0;
    logic [PIX_W-1:0] pix [CH][DEPTH];
    int first_cyc = 0, last_cyc = 0;
    logic [W-1:0] w_first, w_last;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [PIX_W-1:0] pat_val(input int pat, input int c, input int i);
        int v;
        case (pat)
            0:       v = (c == 0) ? (i % 256) : (255 - (i % 256));
            1:       v = (c == 0) ? (i * 7 + 3) : ((i / 8) ^ i);
            2:       v = (c == 0) ? (i * 13 + 100) : (i * 5 + 1);
            default: v = (c == 0) ? (i * 11 + 50) : (i * 3 + 17);
        endcase
        return PIX_W'(v % 256);
    endfunction

    // Word k of channel c is pixels k*PACK.., lane order reversed when rev was set at start.
    function automatic logic [W-1:0] exp_word(input int k);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < PACK; j++)
                w[(c*PACK+j)*PIX_W +: PIX_W] = pix[c][k*PACK + (mdl_rev ? PACK-1-j : j)];
        return w;
    endfunction

    // Compare process: every transferred word against the model, plus stability while stalled.
    logic         hold_pend = 1'b0;
    logic [W-1:0] held = '0;
    always @(negedge CLK) begin
        if (RESET) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", W'(out_valid), W'(1));
                check("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_cnt >= WORDS) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_word: got word %h with none outstanding", out_data);
                end else begin
                    check($sformatf("word%0d", exp_cnt), out_data, exp_word(exp_cnt));
                    if (exp_cnt == 0)       begin w_first = out_data; first_cyc = cyc; end
                    if (exp_cnt == WORDS-1) begin w_last  = out_data; last_cyc  = cyc; end
                    exp_cnt++;
                end
            end
            hold_pend = out_valid && !out_ready;
            held      = out_data;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input bit r);
        mdl_rev = r;
        exp_cnt = 0;
        start   = 1'b1;
        rev     = r;
        tick();
        start   = 1'b0;
        rev     = !r;      // rev must have been latched
        check("start_in_ready", W'(in_ready), W'(1));
        check("start_complete", W'(complete), W'(0));
        check("start_busy", W'(busy), W'(1));
    endtask

    task automatic fill(input int pat, input bit gaps, input int stop_at);
        int g;
        for (int i = 0; i < stop_at; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                in_valid = 1'b0;
                repeat (g) tick();
            end
            for (int c = 0; c < CH; c++) begin
                pix[c][i] = pat_val(pat, c, i);
                in_data[c*PIX_W +: PIX_W] = pix[c][i];
            end
            in_valid = 1'b1;
            if (i == 500) begin
                start = 1'b1;
                rev   = !mdl_rev;
            end
            if (!in_ready) begin
                check($sformatf("fill_ready_%0d", i), W'(in_ready), W'(1));
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit stall, input bit poke);
        int lat;
        int ph;
        check("fill_end_in_ready", W'(in_ready), W'(0));
        check("drain_busy", W'(busy), W'(1));
        lat = 0;
        while (!out_valid && lat < 3) begin
            tick();
            lat++;
        end
        check("first_valid_latency", W'(out_valid && lat <= 2), W'(1));
        ph = 0;
        while (exp_cnt != WORDS && ph < 4 * WORDS + 20) begin
            out_ready = stall ? (ph % 3 == 0) : 1'b1;
            if (poke && ph == 100) begin
                start = 1'b1;
                rev   = !mdl_rev;
            end
            tick();
            start = 1'b0;
            ph++;
        end
        check("drain_count", W'(exp_cnt), W'(WORDS));
        check("done_complete", W'(complete), W'(1));
        check("done_out_valid", W'(out_valid), W'(0));
        check("done_busy", W'(busy), W'(0));
        check("done_in_ready", W'(in_ready), W'(0));
        if (!stall) check("no_bubbles", W'(last_cyc - first_cyc), W'(WORDS - 1));
        out_ready = 1'b1;
        tick();
        check("done_hold_complete", W'(complete), W'(1));
        check("done_hold_valid", W'(out_valid), W'(0));
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; rev = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_complete", W'(complete), W'(0));
        check("rst_out_data", out_data, '0);
        tick();
        RESET = 1'b0;
        tick();

        // Frame A: straight lanes, continuous stream.
        do_start(1'b0);
        out_ready = 1'b1;
        fill(0, 1'b0, DEPTH);
        drain(1'b0, 1'b0);
        check("a_word0", w_first, 64'hFCFDFEFF_03020100);
        check("a_word511", w_last, 64'h00010203_FFFEFDFC);

        // Frame B: started from DONE, reversed lanes, start poked in FILL and DRAIN.
        do_start(1'b1);
        fill(0, 1'b0, DEPTH);
        drain(1'b0, 1'b1);
        check("b_word0", w_first, 64'hFFFEFDFC_00010203);
        check("b_word511", w_last, 64'h03020100_FCFDFEFF);

        // Frame C: consumer ready one cycle in three.
        do_start(1'b0);
        out_ready = 1'b0;
        fill(1, 1'b0, DEPTH);
        drain(1'b1, 1'b0);

        // Frame D: producer gaps, reversed lanes.
        do_start(1'b1);
        out_ready = 1'b1;
        fill(2, 1'b1, DEPTH);
        drain(1'b0, 1'b0);

        // Reset partway through FILL, with start and a handshake pending on the reset edge.
        do_start(1'b0);
        fill(3, 1'b0, 1000);
        exp_cnt  = WORDS;
        RESET    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        RESET = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("mid_rst_in_ready", W'(in_ready), W'(0));
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_complete", W'(complete), W'(0));
        check("mid_rst_out_data", out_data, '0);
        tick();
        check("mid_rst_idle", W'(in_ready), W'(0));
        do_start(1'b0);
        out_ready = 1'b1;
        fill(3, 1'b0, DEPTH);
        drain(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
